// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// funct codes and the datapath select values.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP_EX  = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_control_fsm_if.sv
// Control/datapath bundle: instruction fields and flags in, datapath controls
// and status out. The FSM is the master, the datapath the slave.
interface mips_control_fsm_if;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        PCEn;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  State;
    logic        Illegal;
    logic        Halted;
    logic [31:0] Retired;

    modport master (
        input  Opcode, Funct, Zero,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
               Halted, Retired
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
               Halted, Retired
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Moore control FSM for a multicycle MIPS datapath, with a sticky illegal flag
// and a retired-instruction counter.
module mips_control_fsm
    import mips_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    mips_control_fsm_if.master bus
);

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        retired_d    = retired_q;
        bus.PCEn     = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegDst   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = SRCB_REG;
        bus.ALUOp    = ALUOP_ADD;
        bus.PCSource = PCSRC_ALU;

        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCEn    = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM_SH;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP_EX;
                    OP_HALT:      state_d = S_HALT;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                // Opcode is held by the IR; anything but lw/sw here is a stray.
                if (bus.Opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.Opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_FETCH;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_RTYPE_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_FUNCT;
                if (funct_legal(bus.Funct)) begin
                    state_d = S_RTYPE_WB;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_RTYPE_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_BEQ_EX: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALUOP_SUB;
                bus.PCSource = PCSRC_ALUOUT;
                bus.PCEn     = bus.Zero;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_JUMP_EX: begin
                bus.PCSource = PCSRC_JUMP;
                bus.PCEn     = 1'b1;
                state_d      = S_FETCH;
                retired_d    = retired_q + 32'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Reset must squash writes immediately, not one edge later.
        if (reset) begin
            bus.PCEn     = 1'b0;
            bus.MemRead  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end

    assign bus.State   = reset ? S_FETCH : state_q;
    assign bus.Illegal = reset ? 1'b0 : illegal_q;
    assign bus.Halted  = !reset && (state_q == S_HALT);
    assign bus.Retired = reset ? 32'd0 : retired_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class through
// its state sequence and checks controls, status flags and the retire count.
module tb_mips_control_fsm;
    import mips_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mips_control_fsm_if bus ();

    mips_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Opcode = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
        @(posedge clock); @(posedge clock); @(negedge clock);
        #1;
        checks++; if (bus.State !== 4'(S_FETCH)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.State, S_FETCH); end
        checks++; if ({bus.PCEn, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite} !== 5'b0) begin errors++; $display("FAIL reset_enables: got %b expected 00000", {bus.PCEn, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite}); end
        checks++; if ({bus.Illegal, bus.Halted} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.Illegal, bus.Halted}); end
        checks++; if (bus.Retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", bus.Retired); end
        reset = 1'b0;
        #1;
        checks++; if ({bus.MemRead, bus.IRWrite, bus.PCEn, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource} !== 11'b111_00_01_00_00) begin errors++; $display("FAIL fetch_controls: got %b expected 11100010000", {bus.MemRead, bus.IRWrite, bus.PCEn, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource}); end
        $display("reset: state=%0d retired=%0d", bus.State, bus.Retired);
    endtask

    task automatic test_lw();
        state_e seq [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
        bus.Opcode = OP_LW;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.State !== 4'(seq[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.State, seq[i]); end
            checks++; if (bus.RegWrite !== (seq[i] == S_MEMWB)) begin errors++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, bus.RegWrite, seq[i] == S_MEMWB); end
            checks++; if (bus.MemtoReg !== (seq[i] == S_MEMWB)) begin errors++; $display("FAIL lw_memtoreg[%0d]: got %b expected %b", i, bus.MemtoReg, seq[i] == S_MEMWB); end
            if (seq[i] == S_MEMRD) begin
                checks++; if ({bus.MemRead, bus.IorD} !== 2'b11) begin errors++; $display("FAIL lw_memrd: got %b expected 11", {bus.MemRead, bus.IorD}); end
            end
            if (i < 5) @(negedge clock);
        end
        checks++; if (bus.Retired !== 32'd1) begin errors++; $display("FAIL lw_retired: got %0d expected 1", bus.Retired); end
        $display("lw: retired=%0d", bus.Retired);
    endtask

    task automatic test_beq();
        state_e seq [4] = '{S_FETCH, S_DECODE, S_BEQ_EX, S_FETCH};
        do_reset();
        bus.Opcode = OP_BEQ;
        for (int z = 1; z >= 0; z--) begin
            bus.Zero = z[0];
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++; if (bus.State !== 4'(seq[i])) begin errors++; $display("FAIL beq_state[%0d]: got %0d expected %0d", i, bus.State, seq[i]); end
                if (seq[i] == S_BEQ_EX) begin
                    checks++; if (bus.PCEn !== z[0]) begin errors++; $display("FAIL beq_pcen(zero=%0d): got %b expected %b", z, bus.PCEn, z[0]); end
                    checks++; if ({bus.PCSource, bus.ALUOp, bus.ALUSrcA} !== 5'b01_01_1) begin errors++; $display("FAIL beq_selects: got %b expected 01011", {bus.PCSource, bus.ALUOp, bus.ALUSrcA}); end
                end
                if (i < 3) @(negedge clock);
            end
            $display("beq zero=%0d: retired=%0d", z, bus.Retired);
        end
        bus.Zero = 1'b0;
        checks++; if (bus.Retired !== 32'd2) begin errors++; $display("FAIL beq_retired: got %0d expected 2", bus.Retired); end
    endtask

    task automatic test_rtype_illegal();
        state_e seq [4] = '{S_FETCH, S_DECODE, S_RTYPE_EX, S_FETCH};
        bus.Opcode = OP_RTYPE; bus.Funct = 6'h3F;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.State !== 4'(seq[i])) begin errors++; $display("FAIL rbad_state[%0d]: got %0d expected %0d", i, bus.State, seq[i]); end
            checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rbad_regwrite[%0d]: got %b expected 0", i, bus.RegWrite); end
            if (i < 3) @(negedge clock);
        end
        checks++; if (bus.Illegal !== 1'b1) begin errors++; $display("FAIL rbad_illegal: got %b expected 1", bus.Illegal); end
        checks++; if (bus.Retired !== 32'd2) begin errors++; $display("FAIL rbad_retired: got %0d expected 2", bus.Retired); end
        $display("rtype funct=3f: illegal=%b retired=%0d", bus.Illegal, bus.Retired);
    endtask

    task automatic test_rtype();
        state_e seq [5] = '{S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_FETCH};
        bus.Opcode = OP_RTYPE; bus.Funct = FN_SLT;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.State !== 4'(seq[i])) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, bus.State, seq[i]); end
            if (seq[i] == S_RTYPE_EX) begin
                checks++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} !== 5'b1_00_10) begin errors++; $display("FAIL rtype_ex: got %b expected 10010", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp}); end
            end
            if (seq[i] == S_RTYPE_WB) begin
                checks++; if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b110) begin errors++; $display("FAIL rtype_wb: got %b expected 110", {bus.RegWrite, bus.RegDst, bus.MemtoReg}); end
            end
            if (i < 4) @(negedge clock);
        end
        checks++; if ({bus.Illegal, bus.Retired} !== {1'b1, 32'd3}) begin errors++; $display("FAIL rtype_status: got illegal=%b retired=%0d expected illegal=1 retired=3", bus.Illegal, bus.Retired); end
        $display("rtype funct=2a: retired=%0d", bus.Retired);
    endtask

    task automatic test_addi_jump();
        state_e aseq [5] = '{S_FETCH, S_DECODE, S_ADDI_EX, S_ADDI_WB, S_FETCH};
        state_e jseq [4] = '{S_FETCH, S_DECODE, S_JUMP_EX, S_FETCH};
        bus.Opcode = OP_ADDI;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.State !== 4'(aseq[i])) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, bus.State, aseq[i]); end
            if (aseq[i] == S_ADDI_WB) begin
                checks++; if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b100) begin errors++; $display("FAIL addi_wb: got %b expected 100", {bus.RegWrite, bus.RegDst, bus.MemtoReg}); end
            end
            if (i < 4) @(negedge clock);
        end
        checks++; if (bus.Retired !== 32'd4) begin errors++; $display("FAIL addi_retired: got %0d expected 4", bus.Retired); end
        $display("addi: retired=%0d", bus.Retired);
        bus.Opcode = OP_J;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.State !== 4'(jseq[i])) begin errors++; $display("FAIL j_state[%0d]: got %0d expected %0d", i, bus.State, jseq[i]); end
            if (jseq[i] == S_JUMP_EX) begin
                checks++; if ({bus.PCEn, bus.PCSource, bus.IRWrite} !== 4'b1_10_0) begin errors++; $display("FAIL j_ex: got %b expected 1100", {bus.PCEn, bus.PCSource, bus.IRWrite}); end
            end
            if (i < 3) @(negedge clock);
        end
        checks++; if (bus.Retired !== 32'd5) begin errors++; $display("FAIL j_retired: got %0d expected 5", bus.Retired); end
        $display("j: retired=%0d", bus.Retired);
    endtask

    task automatic test_illegal_opcode();
        do_reset();
        bus.Opcode = 6'h3E;
        #1;
        checks++; if (bus.Illegal !== 1'b0) begin errors++; $display("FAIL illop_clear: got %b expected 0", bus.Illegal); end
        @(negedge clock); #1;
        checks++; if (bus.State !== 4'(S_DECODE)) begin errors++; $display("FAIL illop_decode: got %0d expected %0d", bus.State, S_DECODE); end
        @(negedge clock); #1;
        checks++; if ({bus.State, bus.Illegal} !== {4'(S_FETCH), 1'b1}) begin errors++; $display("FAIL illop_after: got state=%0d illegal=%b expected state=0 illegal=1", bus.State, bus.Illegal); end
        checks++; if (bus.Retired !== 32'd0) begin errors++; $display("FAIL illop_retired: got %0d expected 0", bus.Retired); end
        $display("opcode=3e: illegal=%b retired=%0d", bus.Illegal, bus.Retired);
    endtask

    task automatic test_halt();
        bus.Opcode = OP_HALT;
        @(negedge clock); @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({bus.State, bus.Halted, bus.PCEn, bus.RegWrite, bus.MemWrite} !== {4'(S_HALT), 4'b1000}) begin errors++; $display("FAIL halt_cycle[%0d]: got state=%0d halted=%b pcen=%b expected state=12 halted=1 pcen=0", i, bus.State, bus.Halted, bus.PCEn); end
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        checks++; if ({bus.State, bus.Halted} !== {4'(S_FETCH), 1'b0}) begin errors++; $display("FAIL halt_reset: got state=%0d halted=%b expected state=0 halted=0", bus.State, bus.Halted); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if ({bus.State, bus.Halted, bus.PCEn} !== {4'(S_FETCH), 2'b01}) begin errors++; $display("FAIL halt_release: got state=%0d halted=%b pcen=%b expected state=0 halted=0 pcen=1", bus.State, bus.Halted, bus.PCEn); end
        $display("halt: released by reset, state=%0d", bus.State);
    endtask

    task automatic test_reset_mid();
        bus.Opcode = OP_LW;
        @(negedge clock); @(negedge clock); @(negedge clock);
        #1;
        checks++; if (bus.State !== 4'(S_MEMRD)) begin errors++; $display("FAIL mid_memrd: got %0d expected %0d", bus.State, S_MEMRD); end
        reset = 1'b1;
        #1;
        checks++; if ({bus.MemRead, bus.RegWrite, bus.PCEn} !== 3'b000) begin errors++; $display("FAIL mid_squash: got %b expected 000", {bus.MemRead, bus.RegWrite, bus.PCEn}); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if ({bus.State, bus.Retired} !== {4'(S_FETCH), 32'd0}) begin errors++; $display("FAIL mid_after: got state=%0d retired=%0d expected state=0 retired=0", bus.State, bus.Retired); end
        @(negedge clock); #1;
        checks++; if (bus.State !== 4'(S_DECODE)) begin errors++; $display("FAIL mid_nomemwb: got %0d expected %0d", bus.State, S_DECODE); end
        $display("reset during MEMRD: restarted at fetch");
        do_reset();
    endtask

    task automatic test_wrap();
        state_e seq [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
        dut.retired_q = 32'hFFFF_FFFF;
        bus.Opcode = OP_SW;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.State !== 4'(seq[i])) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus.State, seq[i]); end
            if (seq[i] == S_MEMWR) begin
                checks++; if ({bus.MemWrite, bus.IorD, bus.RegWrite} !== 3'b110) begin errors++; $display("FAIL sw_memwr: got %b expected 110", {bus.MemWrite, bus.IorD, bus.RegWrite}); end
                checks++; if (bus.Retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sw_preload: got %h expected ffffffff", bus.Retired); end
            end
            if (i < 4) @(negedge clock);
        end
        checks++; if (bus.Retired !== 32'd0) begin errors++; $display("FAIL sw_wrap: got %h expected 00000000", bus.Retired); end
        $display("sw from ffffffff: retired=%h", bus.Retired);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_beq();
        test_rtype_illegal();
        test_rtype();
        test_addi_jump();
        test_illegal_opcode();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001: Reset is synchronous, active-high; single clock domain, all state updates on posedge clock.
REQ-002: clock  input  1  system clock, same clock driving the instruction memory stage.
REQ-003: reset  input  1  synchronous active-high reset.
REQ-004: Opcode  input  6  instruction[31:26] from the instruction memory stage; valid from the cycle after FETCH.
REQ-005: Funct  input  6  instruction[5:0], same timing as Opcode.
REQ-006: Zero  input  1  ALU zero flag, combinational from datapath.
REQ-007: PCEn  output  1  PC register write enable.
REQ-008: IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-009: ALUSrcB, ALUOp, PCSource  output  2 each  datapath mux/ALU selects.
REQ-010: State  output  4  current state encoding.
REQ-011: Illegal  output  1  sticky: unsupported opcode/funct seen.
REQ-012: Halted  output  1  halt opcode executed.
REQ-013: Retired  output  32  count of completed instructions.

Function
REQ-014: Moore FSM; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP_EX, HALT.
REQ-015: FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCEn=1 -> DECODE.
REQ-016: DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; dispatch on Opcode: 0x23/0x2B->MEMADR, 0x00->RTYPE_EX, 0x04->BEQ_EX, 0x08->ADDI_EX, 0x02->JUMP_EX, 0x3F->HALT, other->FETCH with Illegal set.
REQ-017: MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Opcode 0x23->MEMRD, 0x2B->MEMWR.
REQ-018: MEMRD: MemRead=1, IorD=1 -> MEMWB; MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-019: MEMWR: MemWrite=1, IorD=1 -> FETCH.
REQ-020: RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPE_WB; Funct outside {0x20,0x22,0x24,0x25,0x2A} -> FETCH, Illegal set, no writeback.
REQ-021: RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-022: BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCEn=Zero -> FETCH.
REQ-023: ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB; ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-024: JUMP_EX: PCSource=10, PCEn=1 -> FETCH.
REQ-025: HALT: all enables 0, Halted=1, stays until reset.
REQ-026: Unlisted outputs are 0 in every state; IRWrite=1 only in FETCH.
REQ-027: Retired increments by 1 on the cycle leaving MEMWB, MEMWR, RTYPE_WB, BEQ_EX, ADDI_WB, JUMP_EX; wraps 0xFFFFFFFF->0; illegal instructions not counted.
REQ-028: Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-029: While reset=1: State=FETCH, all enable outputs forced 0, Retired=0, Illegal=0, Halted=0; first FETCH behaviour in the cycle after reset deasserts.
REQ-030: Reset asserted in any state, including mid-instruction or HALT, aborts with no further register/memory/PC write.

Structure
REQ-031: State encodings, opcode/funct constants and ALUOp/PCSource/ALUSrcB codes live in shared package mips_pkg.
REQ-032: Single module, no sub-modules; output decode as one combinational block from the state register.

Verification
REQ-033: Reset then Opcode=0x23 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; RegWrite=1 and MemtoReg=1 in MEMWB only; Retired=1.
REQ-034: Opcode=0x04, Zero=1 in BEQ_EX -> PCEn=1, PCSource=01; repeat with Zero=0 -> PCEn=0; Retired=2.
REQ-035: Opcode=0x00, Funct=0x3F -> DECODE,RTYPE_EX,FETCH; Illegal=1 thereafter, RegWrite never 1, Retired unchanged.
REQ-036: Opcode=0x3F -> HALT with Halted=1, PCEn=0 for 10 cycles; reset -> FETCH, Halted=0.
REQ-037: Reset pulsed during MEMRD -> no MEMWB, State=FETCH, Retired=0.
REQ-038: Force Retired=0xFFFFFFFF, complete one sw -> Retired=0.
